// File: rtl/aes_pkg.sv
// aes_pkg: shared AES types, round-count constants and GF(2^8) helpers.
// The xtime/gf_mul helpers are shared with the encrypt-side round chain.
package aes_pkg;

  typedef logic [127:0] aes_block_t;
  typedef logic [7:0]   aes_byte_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    FINAL = 2'd2
  } state_t;

  localparam int AES_NR_128 = 10;
  localparam int AES_NR_192 = 12;
  localparam int AES_NR_256 = 14;

  // Multiply by x modulo x^8 + x^4 + x^3 + x + 1 (0x11B).
  function automatic aes_byte_t xtime(input aes_byte_t b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic aes_byte_t gf_mul_9(input aes_byte_t b);
    aes_byte_t x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ b;
  endfunction

  function automatic aes_byte_t gf_mul_b(input aes_byte_t b);
    aes_byte_t x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ x2 ^ b;
  endfunction

  function automatic aes_byte_t gf_mul_d(input aes_byte_t b);
    aes_byte_t x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ x4 ^ b;
  endfunction

  function automatic aes_byte_t gf_mul_e(input aes_byte_t b);
    aes_byte_t x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ x4 ^ x2;
  endfunction

  // Byte k sits at [127-8k -: 8]; row = k%4, column = k/4. Row r rotates right by r.
  function automatic aes_block_t inv_shift_rows(input aes_block_t s);
    aes_block_t o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127 - 8*(4*c + r) -: 8] = s[127 - 8*(4*((c - r + 4) % 4) + r) -: 8];
      end
    end
    return o;
  endfunction

  // Column-wise multiply by the inverse MixColumns matrix {0e,0b,0d,09}.
  function automatic aes_block_t inv_mix_columns(input aes_block_t s);
    aes_block_t o;
    aes_byte_t  a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127 - 32*c -: 8];
      a1 = s[119 - 32*c -: 8];
      a2 = s[111 - 32*c -: 8];
      a3 = s[103 - 32*c -: 8];
      o[127 - 32*c -: 8] = gf_mul_e(a0) ^ gf_mul_b(a1) ^ gf_mul_d(a2) ^ gf_mul_9(a3);
      o[119 - 32*c -: 8] = gf_mul_9(a0) ^ gf_mul_e(a1) ^ gf_mul_b(a2) ^ gf_mul_d(a3);
      o[111 - 32*c -: 8] = gf_mul_d(a0) ^ gf_mul_9(a1) ^ gf_mul_e(a2) ^ gf_mul_b(a3);
      o[103 - 32*c -: 8] = gf_mul_b(a0) ^ gf_mul_d(a1) ^ gf_mul_9(a2) ^ gf_mul_e(a3);
    end
    return o;
  endfunction

endpackage

// File: rtl/aes_inv_cipher_core_if.sv
// aes_inv_cipher_core_if: start/busy/done handshake, data and round-key fetch bus.
// The abort signal exists only when AES_INV_CIPHER_ABORT_EN is defined.
interface aes_inv_cipher_core_if;
  import aes_pkg::*;

  logic       start;
  aes_block_t data_in;
  logic [3:0] rk_idx;
  aes_block_t round_key;
  aes_block_t data_out;
  logic       busy;
  logic       done;
`ifdef AES_INV_CIPHER_ABORT_EN
  logic       abort;

  modport master (output start, data_in, round_key, abort,
                  input  rk_idx, data_out, busy, done);
  modport slave  (input  start, data_in, round_key, abort,
                  output rk_idx, data_out, busy, done);
`else
  modport master (output start, data_in, round_key,
                  input  rk_idx, data_out, busy, done);
  modport slave  (input  start, data_in, round_key,
                  output rk_idx, data_out, busy, done);
`endif

endinterface

// File: rtl/aes_inv_sbox.sv
// aes_inv_sbox: combinational AES inverse S-box lookup, one byte.
module aes_inv_sbox (
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte
);

  // Entry 0 occupies the top byte; entry n sits at bit offset (255-n)*8.
  localparam logic [2047:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  logic [10:0] w_bit_idx;

  assign w_bit_idx = {~i_byte, 3'b000};
  assign o_byte    = INV_SBOX[w_bit_idx +: 8];

endmodule

// File: rtl/aes_inv_cipher_core.sv
// aes_inv_cipher_core: iterative AES inverse cipher, one round per clock.
// Round keys are fetched by index (rk_idx) from an external key-schedule store.
// Optional abort input enabled by defining AES_INV_CIPHER_ABORT_EN.
module aes_inv_cipher_core
  import aes_pkg::*;
#(
  parameter int NR = AES_NR_128
) (
  input  logic                 clk,
  input  logic                 g_rst_n,
  aes_inv_cipher_core_if.slave bus
);

  localparam logic [3:0] NR_W  = 4'(NR);
  localparam logic [3:0] NR_M1 = 4'(NR - 1);

  generate
    if (NR != AES_NR_128 && NR != AES_NR_192 && NR != AES_NR_256) begin : g_bad_nr
      $error("aes_inv_cipher_core: NR must be 10, 12 or 14");
    end
  endgenerate

  state_t     r_fsm;
  logic [3:0] r_round;
  aes_block_t r_state;
  aes_block_t r_data_out;
  logic       r_busy;
  logic       r_done;

  aes_block_t w_initial;
  aes_block_t w_shifted;
  aes_block_t w_subbed;
  aes_block_t w_added;
  aes_block_t w_mixed;
  logic [3:0] w_rk_idx;
  logic       w_abort;

  // Round datapath: InvShiftRows -> InvSubBytes -> AddRoundKey -> InvMixColumns.
  assign w_initial = bus.data_in ^ bus.round_key;
  assign w_shifted = inv_shift_rows(r_state);

  for (genvar k = 0; k < 16; k++) begin : g_sbox
    aes_inv_sbox u_inv_sbox (
      .i_byte (w_shifted[127 - 8*k -: 8]),
      .o_byte (w_subbed[127 - 8*k -: 8])
    );
  end

  assign w_added = w_subbed ^ bus.round_key;
  assign w_mixed = inv_mix_columns(w_added);

`ifdef AES_INV_CIPHER_ABORT_EN
  assign w_abort = bus.abort;
`else
  assign w_abort = 1'b0;
`endif

  // Select which round key the external store must present this cycle.
  always_comb begin
    w_rk_idx = NR_W;
    case (r_fsm)
      IDLE:    w_rk_idx = NR_W;
      ROUND:   w_rk_idx = r_round;
      FINAL:   w_rk_idx = 4'd0;
      default: w_rk_idx = NR_W;
    endcase
  end

  // Control FSM and state register: accept, NR-1 full rounds, final round.
  always_ff @(posedge clk or negedge g_rst_n) begin
    if (!g_rst_n) begin
      r_fsm      <= IDLE;
      r_round    <= NR_W;
      r_state    <= '0;
      r_data_out <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_abort && (r_fsm != IDLE)) begin
        // Abandon the block; data_out keeps the last completed result.
        r_fsm   <= IDLE;
        r_state <= '0;
        r_busy  <= 1'b0;
        r_round <= NR_W;
      end else begin
        case (r_fsm)
          IDLE: begin
            if (bus.start) begin
              r_state <= w_initial;
              r_round <= NR_M1;
              r_busy  <= 1'b1;
              r_fsm   <= ROUND;
            end
          end
          ROUND: begin
            r_state <= w_mixed;
            r_round <= r_round - 4'd1;
            if (r_round == 4'd1) begin
              r_fsm <= FINAL;
            end
          end
          FINAL: begin
            r_data_out <= w_added;
            r_done     <= 1'b1;
            r_busy     <= 1'b0;
            r_round    <= NR_W;
            r_fsm      <= IDLE;
          end
          default: begin
            r_fsm   <= IDLE;
            r_state <= '0;
            r_busy  <= 1'b0;
            r_round <= NR_W;
          end
        endcase
      end
    end
  end

  assign bus.rk_idx   = w_rk_idx;
  assign bus.data_out = r_data_out;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;

endmodule

// File: tb/tb_aes_inv_cipher_core.sv
// tb_aes_inv_cipher_core: self-checking bench for the AES inverse cipher core.
// Runs an NR=10 and an NR=14 instance; expected plaintexts come from FIPS-197
// vectors and from a forward AES model (key expansion + encryption) kept here.
module tb_aes_inv_cipher_core;

  logic clk     = 1'b0;
  logic g_rst_n = 1'b0;
  int   total   = 0;
  int   bad     = 0;
  int   cyc     = 0;

  logic [7:0]   sbox_t [256];
  logic [127:0] rk10 [16];
  logic [127:0] rk14 [16];
  logic [127:0] exp_out10;

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [255:0] C3_KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] C3_CT  = 128'h8ea2b7ca516745bfeafc49904b496089;

  always #5 clk = ~clk;

  aes_inv_cipher_core_if bus10 ();
  aes_inv_cipher_core_if bus14 ();

  // Key-schedule stores: combinational lookup by rk_idx.
  assign bus10.round_key = rk10[bus10.rk_idx];
  assign bus14.round_key = rk14[bus14.rk_idx];

  aes_inv_cipher_core #(.NR(10)) dut10 (.clk(clk), .g_rst_n(g_rst_n), .bus(bus10.slave));
  aes_inv_cipher_core #(.NR(14)) dut14 (.clk(clk), .g_rst_n(g_rst_n), .bus(bus14.slave));

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Forward S-box from its definition: multiplicative inverse then affine map.
  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv, b;
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      end
      b = inv;
      sbox_t[x] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subword(input logic [31:0] w);
    return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
  endfunction

  // Key expansion; AES-128 keys sit in key[255:128]. nr selects the store.
  task automatic expand_key(input logic [255:0] key, input int nr);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc;
    int nk;
    nk = nr - 6;
    rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[255 - 32*i -: 32];
    for (int i = nk; i < 4*(nr + 1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t  = subword({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
        rc = gmul(rc, 8'h02);
      end else if (nk > 6 && i % nk == 4) begin
        t = subword(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r <= nr; r++) begin
      if (nr == 14) rk14[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      else          rk10[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    end
  endtask

  function automatic logic [127:0] rk_of(input int nr, input int r);
    return (nr == 14) ? rk14[r] : rk10[r];
  endfunction

  // Forward cipher over a byte array (index = row + 4*column).
  function automatic logic [127:0] encrypt(input logic [127:0] pt, input int nr);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] k, o;
    k = rk_of(nr, 0);
    for (int i = 0; i < 16; i++) s[i] = pt[127 - 8*i -: 8] ^ k[127 - 8*i -: 8];
    for (int rnd = 1; rnd <= nr; rnd++) begin
      for (int i = 0; i < 16; i++) t[i] = sbox_t[s[i]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) s[r + 4*c] = t[r + 4*((c + r) % 4)];
      if (rnd != nr) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
          s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
        end
      end
      k = rk_of(nr, rnd);
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ k[127 - 8*i -: 8];
    end
    o = '0;
    for (int i = 0; i < 16; i++) o[127 - 8*i -: 8] = s[i];
    return o;
  endfunction

  // ---------------- bench plumbing ----------------
  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic get_done(input int nr);
    return (nr == 14) ? bus14.done : bus10.done;
  endfunction

  function automatic logic get_busy(input int nr);
    return (nr == 14) ? bus14.busy : bus10.busy;
  endfunction

  function automatic logic [3:0] get_idx(input int nr);
    return (nr == 14) ? bus14.rk_idx : bus10.rk_idx;
  endfunction

  function automatic logic [127:0] get_out(input int nr);
    return (nr == 14) ? bus14.data_out : bus10.data_out;
  endfunction

  task automatic set_in(input int nr, input logic st, input logic [127:0] d);
    if (nr == 14) begin
      bus14.start   = st;
      bus14.data_in = d;
    end else begin
      bus10.start   = st;
      bus10.data_in = d;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Start one block now and follow it to its done cycle (returns in that cycle).
  task automatic run_block(input int nr, input logic [127:0] ct, input logic [127:0] exp,
                           input string name, input int spur, output int done_cyc);
    int         k;
    int         busy_cnt;
    bit         idx_ok;
    logic [3:0] want_idx;
    set_in(nr, 1'b1, ct);
    total++;
    if (get_idx(nr) !== 4'(nr)) begin
      bad++;
      $display("FAIL %s idle_rk_idx: got %0d want %0d", name, get_idx(nr), nr);
    end
    tick();
    k        = 0;
    busy_cnt = 0;
    idx_ok   = 1'b1;
    while (get_done(nr) !== 1'b1 && k < nr + 4) begin
      set_in(nr, (k == spur), rnd128());
      if (get_busy(nr) === 1'b1) busy_cnt++;
      want_idx = (k < nr - 1) ? 4'(nr - 1 - k) : 4'd0;
      if (get_idx(nr) !== want_idx) idx_ok = 1'b0;
      tick();
      k++;
    end
    set_in(nr, 1'b0, rnd128());
    done_cyc = cyc;
    if (nr == 10) exp_out10 = exp;
    total++;
    if (get_done(nr) !== 1'b1 || k != nr) begin
      bad++;
      $display("FAIL %s latency: done=%b after %0d cycles, want done=1 after %0d", name, get_done(nr), k, nr);
    end
    total++;
    if (get_out(nr) !== exp) begin
      bad++;
      $display("FAIL %s data_out: got %h want %h", name, get_out(nr), exp);
    end
    total++;
    if (busy_cnt != nr || get_busy(nr) !== 1'b0) begin
      bad++;
      $display("FAIL %s busy: high %0d cycles, busy at done=%b, want %0d cycles and 0", name, busy_cnt, get_busy(nr), nr);
    end
    total++;
    if (!idx_ok || get_idx(nr) !== 4'(nr)) begin
      bad++;
      $display("FAIL %s rk_idx_seq: sequence ok=%0d, idx at done=%0d, want ok=1 and %0d", name, idx_ok, get_idx(nr), nr);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    for (int n = 10; n <= 14; n += 4) begin
      total++;
      if (get_busy(n) !== 1'b0) begin bad++; $display("FAIL reset_busy nr%0d: got %b want 0", n, get_busy(n)); end
      total++;
      if (get_done(n) !== 1'b0) begin bad++; $display("FAIL reset_done nr%0d: got %b want 0", n, get_done(n)); end
      total++;
      if (get_out(n) !== 128'h0) begin bad++; $display("FAIL reset_data_out nr%0d: got %h want 0", n, get_out(n)); end
      total++;
      if (get_idx(n) !== 4'(n)) begin bad++; $display("FAIL reset_rk_idx nr%0d: got %0d want %0d", n, get_idx(n), n); end
    end
  endtask

  task automatic test_c1();
    int dc;
    expand_key({C1_KEY, 128'h0}, 10);
    run_block(10, C1_CT, C1_PT, "c1", -1, dc);
    tick();
    total++;
    if (bus10.done !== 1'b0) begin bad++; $display("FAIL c1 done_width: done=%b one cycle later, want 0", bus10.done); end
    total++;
    if (bus10.data_out !== C1_PT) begin bad++; $display("FAIL c1 data_out_hold: got %h want %h", bus10.data_out, C1_PT); end
  endtask

  task automatic test_appb();
    int dc;
    expand_key({B_KEY, 128'h0}, 10);
    run_block(10, B_CT, B_PT, "appb", -1, dc);
    tick();
  endtask

  task automatic test_back_to_back();
    int d1, d2;
    expand_key({C1_KEY, 128'h0}, 10);
    run_block(10, C1_CT, C1_PT, "b2b_first", 5, d1);
    expand_key({B_KEY, 128'h0}, 10);
    run_block(10, B_CT, B_PT, "b2b_second", -1, d2);
    total++;
    if (d2 - d1 != 11) begin bad++; $display("FAIL b2b spacing: got %0d cycles want 11", d2 - d1); end
    tick();
    total++;
    if (bus10.busy !== 1'b0 || bus10.done !== 1'b0) begin
      bad++;
      $display("FAIL b2b no_queue: busy=%b done=%b want 0 0", bus10.busy, bus10.done);
    end
  endtask

  task automatic test_reset_mid();
    int dc;
    bit saw_done;
    expand_key({C1_KEY, 128'h0}, 10);
    set_in(10, 1'b1, C1_CT);
    tick();
    set_in(10, 1'b0, rnd128());
    repeat (3) tick();
    g_rst_n = 1'b0;
    #1;
    total++;
    if (bus10.busy !== 1'b0) begin bad++; $display("FAIL rstmid busy: got %b want 0", bus10.busy); end
    total++;
    if (bus10.data_out !== 128'h0) begin bad++; $display("FAIL rstmid data_out: got %h want 0", bus10.data_out); end
    total++;
    if (bus10.rk_idx !== 4'd10) begin bad++; $display("FAIL rstmid rk_idx: got %0d want 10", bus10.rk_idx); end
    saw_done = 1'b0;
    repeat (2) begin
      tick();
      if (bus10.done !== 1'b0) saw_done = 1'b1;
    end
    g_rst_n = 1'b1;
    repeat (12) begin
      tick();
      if (bus10.done !== 1'b0 || bus10.busy !== 1'b0) saw_done = 1'b1;
    end
    total++;
    if (saw_done) begin bad++; $display("FAIL rstmid no_done: activity seen=1 want 0"); end
    exp_out10 = 128'h0;
    run_block(10, C1_CT, C1_PT, "rstmid_rerun", -1, dc);
    tick();
  endtask

  task automatic test_nr14();
    int dc;
    logic [255:0] key;
    logic [127:0] pt;
    expand_key(C3_KEY, 14);
    run_block(14, C3_CT, C1_PT, "c3_nr14", -1, dc);
    for (int i = 0; i < 2; i++) begin
      key = {rnd128(), rnd128()};
      pt  = rnd128();
      expand_key(key, 14);
      run_block(14, encrypt(pt, 14), pt, "rand_nr14", -1, dc);
    end
    tick();
  endtask

  task automatic test_random();
    int dc;
    logic [127:0] key, pt;
    for (int i = 0; i < 6; i++) begin
      key = rnd128();
      pt  = rnd128();
      expand_key({key, 128'h0}, 10);
      run_block(10, encrypt(pt, 10), pt, "rand_nr10", (i % 2 == 0) ? 3 : -1, dc);
    end
    tick();
  endtask

`ifdef AES_INV_CIPHER_ABORT_EN
  task automatic test_abort();
    int k;
    bit saw_done;
    expand_key({C1_KEY, 128'h0}, 10);
    set_in(10, 1'b1, C1_CT);
    tick();
    set_in(10, 1'b0, rnd128());
    repeat (5) tick();
    bus10.abort = 1'b1;
    tick();
    bus10.abort = 1'b0;
    total++;
    if (bus10.busy !== 1'b0) begin bad++; $display("FAIL abort busy: got %b want 0", bus10.busy); end
    total++;
    if (bus10.data_out !== exp_out10) begin bad++; $display("FAIL abort data_out: got %h want %h", bus10.data_out, exp_out10); end
    saw_done = (bus10.done !== 1'b0);
    repeat (14) begin
      tick();
      if (bus10.done !== 1'b0) saw_done = 1'b1;
    end
    total++;
    if (saw_done) begin bad++; $display("FAIL abort no_done: done seen=1 want 0"); end
    bus10.abort = 1'b1;
    set_in(10, 1'b1, C1_CT);
    tick();
    bus10.abort = 1'b0;
    set_in(10, 1'b0, rnd128());
    total++;
    if (bus10.busy !== 1'b1) begin bad++; $display("FAIL abort_start busy: got %b want 1", bus10.busy); end
    k = 0;
    while (bus10.done !== 1'b1 && k < 14) begin
      tick();
      k++;
    end
    total++;
    if (k != 10 || bus10.data_out !== C1_PT) begin
      bad++;
      $display("FAIL abort_start result: %0d cycles data %h, want 10 cycles data %h", k, bus10.data_out, C1_PT);
    end
    tick();
  endtask
`endif

  initial begin
    set_in(10, 1'b0, 128'h0);
    set_in(14, 1'b0, 128'h0);
`ifdef AES_INV_CIPHER_ABORT_EN
    bus10.abort = 1'b0;
    bus14.abort = 1'b0;
`endif
    for (int r = 0; r < 16; r++) begin
      rk10[r] = 128'h0;
      rk14[r] = 128'h0;
    end
    exp_out10 = 128'h0;
    build_sbox();
    tick();
    tick();
    test_reset();
    g_rst_n = 1'b1;
    tick();
    test_c1();
    test_appb();
    test_back_to_back();
    test_reset_mid();
    test_nr14();
    test_random();
`ifdef AES_INV_CIPHER_ABORT_EN
    test_abort();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want summary before it");
    $fatal(1, "watchdog");
  end

endmodule
